// File: rtl/jstk_paddle_ctrl.sv
// PmodJSTK frame -> paddle row: centre calibration, 4-tap Y smoothing, dead zone, per-frame clamped move.
// Optional macro PADDLE_ACCEL_EN doubles the step for deflections beyond 4*DEADZONE.
module jstk_paddle_ctrl #(
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int PADDLE_H = 64,
  parameter int DEADZONE = 64,
  parameter int SPEED    = 4,
  parameter int RESET_Y  = 208
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        jstk_valid,
  input  logic [39:0] jstk_data,
  input  logic        frame_tick,
  input  logic        enable,
  output logic [9:0]  paddle_y,
  output logic        cal_done,
  output logic        btn_left,
  output logic        btn_right
);

  typedef enum logic {CAL, RUN} state_t;

  localparam logic signed [10:0] DZ_POS = 11'(DEADZONE);
  localparam logic signed [10:0] DZ_NEG = 11'(-DEADZONE);
  localparam logic signed [10:0] Y_LO   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_HI   = 11'(Y_MAX + 1 - PADDLE_H);
  localparam logic signed [10:0] STEP_N = 11'(SPEED);

  state_t       state_reg, state_next;
  logic [2:0]   cal_cnt_reg;
  logic [12:0]  cal_acc_reg;
  logic [9:0]   centre_reg;
  logic [9:0]   tap_reg [4];
  logic [9:0]   tap_in  [4];
  logic [11:0]  sum_reg;
  logic [9:0]   avg_reg;
  logic [9:0]   paddle_y_reg;
  logic         cal_done_reg, btn_left_reg, btn_right_reg;

  logic [9:0]   y_raw;
  logic [12:0]  acc_total;
  logic [9:0]   centre_new;
  logic [11:0]  sum_next;
  logic         cal_last;
  logic signed [10:0] defl, step, pos_sum, paddle_next;

  assign y_raw      = {jstk_data[9:8], jstk_data[23:16]};
  assign acc_total  = cal_acc_reg + {3'b000, y_raw};
  assign centre_new = acc_total[12:3];
  assign sum_next   = sum_reg + {2'b00, y_raw} - {2'b00, tap_reg[3]};

  // Window shift wiring: tap 0 takes the new sample, each later tap its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign tap_in[gi] = y_raw;
      end else begin : g_tail
        assign tap_in[gi] = tap_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cal_last   = 1'b0;
    if (state_reg == CAL && jstk_valid && cal_cnt_reg == 3'd7) begin
      cal_last   = 1'b1;
      state_next = RUN;
    end
  end

  // Positive deflection (stick up) moves the paddle toward row 0.
  always_comb begin
    defl = $signed({1'b0, avg_reg}) - $signed({1'b0, centre_reg});
    step = '0;
`ifdef PADDLE_ACCEL_EN
    if (defl > (DZ_POS <<< 2))      step = -(STEP_N <<< 1);
    else if (defl > DZ_POS)         step = -STEP_N;
    else if (defl < (DZ_NEG <<< 2)) step = STEP_N <<< 1;
    else if (defl < DZ_NEG)         step = STEP_N;
`else
    if (defl > DZ_POS)              step = -STEP_N;
    else if (defl < DZ_NEG)         step = STEP_N;
`endif
    pos_sum     = $signed({1'b0, paddle_y_reg}) + step;
    paddle_next = pos_sum;
    if (pos_sum < Y_LO)      paddle_next = Y_LO;
    else if (pos_sum > Y_HI) paddle_next = Y_HI;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg     <= CAL;
      cal_cnt_reg   <= '0;
      cal_acc_reg   <= '0;
      centre_reg    <= 10'd512;
      sum_reg       <= 12'd2048;
      avg_reg       <= 10'd512;
      paddle_y_reg  <= 10'(RESET_Y);
      cal_done_reg  <= 1'b0;
      btn_left_reg  <= 1'b0;
      btn_right_reg <= 1'b0;
      for (int i = 0; i < 4; i++) tap_reg[i] <= 10'd512;
    end else begin
      state_reg <= state_next;
      if (jstk_valid) begin
        btn_left_reg  <= jstk_data[2];
        btn_right_reg <= jstk_data[1];
      end
      if (state_reg == CAL) begin
        if (jstk_valid) begin
          if (cal_last) begin
            centre_reg   <= centre_new;
            avg_reg      <= centre_new;
            sum_reg      <= {centre_new, 2'b00};
            cal_done_reg <= 1'b1;
            cal_cnt_reg  <= '0;
            cal_acc_reg  <= '0;
            for (int i = 0; i < 4; i++) tap_reg[i] <= centre_new;
          end else begin
            cal_acc_reg <= acc_total;
            cal_cnt_reg <= cal_cnt_reg + 3'd1;
          end
        end
      end else begin
        // Movement reads avg_reg before this edge's sample lands.
        if (frame_tick && enable) paddle_y_reg <= paddle_next[9:0];
        if (jstk_valid) begin
          sum_reg <= sum_next;
          avg_reg <= sum_next[11:2];
          for (int i = 0; i < 4; i++) tap_reg[i] <= tap_in[i];
        end
      end
    end
  end

  assign paddle_y  = paddle_y_reg;
  assign cal_done  = cal_done_reg;
  assign btn_left  = btn_left_reg;
  assign btn_right = btn_right_reg;

endmodule

// File: tb/tb_jstk_paddle_ctrl.sv
// Scoreboard bench for jstk_paddle_ctrl: stimulus queues expected outputs, a negedge monitor compares.
module tb_jstk_paddle_ctrl;

  localparam int S = 4;
`ifdef PADDLE_ACCEL_EN
  localparam int F = 8;
`else
  localparam int F = 4;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        jstk_valid = 1'b0;
  logic [39:0] jstk_data = '0;
  logic        frame_tick = 1'b0;
  logic        enable = 1'b1;
  logic [9:0]  paddle_y;
  logic        cal_done, btn_left, btn_right;

  jstk_paddle_ctrl dut (
    .clk(clk), .clr(clr), .jstk_valid(jstk_valid), .jstk_data(jstk_data),
    .frame_tick(frame_tick), .enable(enable), .paddle_y(paddle_y),
    .cal_done(cal_done), .btn_left(btn_left), .btn_right(btn_right)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [9:0] py;
    logic       cd;
    logic       bl;
    logic       br;
  } obs_t;

  obs_t exp_q[$];
  logic chk_req = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  int exp_py = 208;
  bit exp_cd = 0, exp_bl = 0, exp_br = 0;

  // Monitor: one popped expectation per requested observation.
  always @(negedge clk) begin
    if (chk_req) begin
      obs_t e, a;
      a = '{py: paddle_y, cd: cal_done, bl: btn_left, br: btn_right};
      checks++;
      txn++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL txn%0d scoreboard_empty got py=%0d cd=%0b bl=%0b br=%0b", txn, a.py, a.cd, a.bl, a.br);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL txn%0d outputs got py=%0d cd=%0b bl=%0b br=%0b expected py=%0d cd=%0b bl=%0b br=%0b",
                   txn, a.py, a.cd, a.bl, a.br, e.py, e.cd, e.bl, e.br);
        end else begin
          $display("txn%0d ok py=%0d cd=%0b bl=%0b br=%0b", txn, a.py, a.cd, a.bl, a.br);
        end
      end
    end
  end

  function automatic logic [39:0] mk(input int y, input bit bl, input bit br);
    logic [39:0] f;
    logic [9:0]  yv;
    yv = 10'(y);
    f = 40'hA5C3_00FC_F9;
    f[23:16] = yv[7:0];
    f[9:8]   = yv[9:8];
    f[2]     = bl;
    f[1]     = br;
    return f;
  endfunction

  function automatic int clampy(input int v);
    if (v < 0)   return 0;
    if (v > 416) return 416;
    return v;
  endfunction

  task automatic expect_now();
    exp_q.push_back('{py: 10'(exp_py), cd: exp_cd, bl: exp_bl, br: exp_br});
    chk_req = 1'b1;
    @(posedge clk); #1;
    chk_req = 1'b0;
  endtask

  task automatic drive(input bit v, input int y, input bit bl, input bit br, input bit t);
    jstk_valid = v;
    jstk_data  = mk(y, bl, br);
    frame_tick = t;
    @(posedge clk); #1;
    jstk_valid = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic valid(input int y, input bit bl, input bit br, input bit last_cal);
    drive(1'b1, y, bl, br, 1'b0);
    exp_bl = bl; exp_br = br;
    if (last_cal) exp_cd = 1'b1;
    expect_now();
  endtask

  task automatic fill(input int y, input bit bl, input bit br);
    for (int i = 0; i < 4; i++) valid(y, bl, br, 1'b0);
  endtask

  task automatic ticks(input int n, input int step);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_py = clampy(exp_py + step);
      expect_now();
    end
  endtask

  task automatic pulse_clr(input bit with_valid);
    clr = 1'b1;
    drive(with_valid, 900, 1'b1, 1'b1, 1'b1);
    clr = 1'b0;
    exp_py = 208; exp_cd = 0; exp_bl = 0; exp_br = 0;
    expect_now();
  endtask

  task automatic calibrate(input int y);
    for (int i = 0; i < 7; i++) valid(y, 1'b0, 1'b0, 1'b0);
    valid(y, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    pulse_clr(1'b0);
    // CAL: ticks ignored
    ticks(2, 0);
    // 8 valids at 500; the 8th coincides with a frame_tick (no movement)
    for (int i = 0; i < 7; i++) valid(500, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 500, 1'b0, 1'b0, 1'b1);
    exp_cd = 1'b1;
    expect_now();

    // stick up d=400
    fill(900, 1'b1, 1'b0);
    ticks(3, -F);                       // 196 (accel 184)

    // dead zone edge d=64 then d=65
    fill(564, 1'b0, 1'b1);
    ticks(10, 0);
    fill(565, 1'b0, 1'b0);
    ticks(1, -S);

    // enable low: hold, buttons still tracked
    enable = 1'b0;
    valid(900, 1'b1, 1'b0, 1'b0);
    valid(900, 1'b0, 1'b1, 1'b0);
    valid(900, 1'b1, 1'b1, 1'b0);
    valid(900, 1'b0, 1'b0, 1'b0);
    ticks(5, 0);
    enable = 1'b1;

    // valid+tick same edge uses old avg 900; then avg=700 (d=200)
    drive(1'b1, 100, 1'b1, 1'b0, 1'b1);
    exp_bl = 1; exp_br = 0;
    exp_py = clampy(exp_py - F);
    expect_now();
    ticks(1, -S);

    // top clamp
    fill(1000, 1'b0, 1'b0);
    ticks(50, -F);

    // 4*DEADZONE boundaries
    fill(244, 1'b0, 1'b0);              // d=-256
    ticks(1, S);
    fill(243, 1'b0, 1'b0);              // d=-257
    ticks(1, F);
    fill(756, 1'b0, 1'b0);              // d=256
    ticks(1, -S);
    fill(757, 1'b0, 1'b0);              // d=257
    ticks(1, -F);

    // bottom clamp
    fill(100, 1'b0, 1'b0);
    ticks(110, F);

    // clr in RUN (with a concurrent valid) forces recalibration
    pulse_clr(1'b1);
    ticks(3, 0);
    calibrate(600);
    fill(664, 1'b0, 1'b0);              // d=64
    ticks(1, 0);
    fill(665, 1'b0, 1'b0);              // d=65
    ticks(1, -S);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jstk_paddle_ctrl.md
Name: jstk_paddle_ctrl

Overview:
Converts raw PmodJSTK frames into a registered on-screen paddle position for the VGA renderer. The block sits directly downstream of the joystick SPI reader (`joy`, 40-bit `DOUT`) and upstream of `vga640x480`, with one instance per player. It self-calibrates the stick centre after reset, smooths the Y axis, and applies a dead zone. It then moves the paddle once per video frame, clamped to the playfield.

Parameters:
- Y_MIN, 0, topmost legal paddle_y (row).
- Y_MAX, 479, bottom playfield row.
- PADDLE_H, 64, paddle height in rows.
- DEADZONE, 64, absolute deflection (raw counts) below which the paddle does not move.
- SPEED, 4, rows moved per frame_tick outside the dead zone.
- RESET_Y, 208, paddle_y after reset, equal to (Y_MIN+Y_MAX+1-PADDLE_H)/2.

Ports:
- clk, in, 1, system clock (50 MHz).
- clr, in, 1, synchronous active-high reset.
- jstk_valid, in, 1, one-cycle strobe: jstk_data holds a new frame.
- jstk_data, in, 40, raw PmodJSTK frame.
- frame_tick, in, 1, one-cycle strobe per video frame.
- enable, in, 1, 1 = game running, paddle may move.
- paddle_y, out, 10, top row of paddle (registered).
- cal_done, out, 1, 1 once centre calibration is complete.
- btn_left, out, 1, registered jstk_data[2].
- btn_right, out, 1, registered jstk_data[1].

Behaviour:
- All state is updated only on the rising edge of clk. clr has priority over every other input.
- Reset values:
  - paddle_y = RESET_Y, cal_done = 0, btn_left = 0, btn_right = 0.
  - state = CAL, sample count = 0, accumulator = 0, centre = 512.
  - averaging window = 4 x 512, avg = 512.
- Raw Y extraction: y_raw = {jstk_data[9:8], jstk_data[23:16]}, unsigned 10-bit.
- On every jstk_valid edge, in any state: btn_left and btn_right load from the frame and are visible the next cycle.
- State CAL:
  - Each jstk_valid adds y_raw to a 13-bit accumulator and increments a 3-bit count.
  - On the 8th valid: centre = (acc + y_raw) >> 3 (truncating). All 4 window taps and avg load centre. cal_done goes to 1 and state goes to RUN at that same edge.
  - paddle_y is frozen in CAL regardless of enable and frame_tick.
- State RUN, smoothing:
  - Each jstk_valid shifts y_raw into a 4-tap window. A 12-bit running sum is updated as sum + new - oldest.
  - avg = sum >> 2, registered. avg reflects a sample one cycle after its jstk_valid edge.
- State RUN, deflection:
  - d = avg - centre, 11-bit signed.
  - Stick up gives d > DEADZONE: step = -SPEED.
  - Stick down gives d < -DEADZONE: step = +SPEED.
  - Otherwise step = 0. |d| == DEADZONE counts as inside the dead zone.
- Movement:
  - On an edge with frame_tick & enable & state==RUN: paddle_y <= clamp(paddle_y + step).
  - The sum is computed 11-bit signed, clamped to [Y_MIN, Y_MAX+1-PADDLE_H], and never wraps.
  - Otherwise paddle_y holds.
- Simultaneous events:
  - jstk_valid and frame_tick on the same edge: movement uses the avg registered before that edge.
  - The CAL→RUN transition edge with frame_tick: no movement.
- enable deasserted: paddle_y holds; smoothing continues.
- clr mid-operation: all values return to reset, state returns to CAL, and recalibration is required.
- Latency:
  - jstk_valid to avg: 1 cycle.
  - frame_tick to paddle_y: 1 cycle (registered output).

Optional Feature:
- Macro: PADDLE_ACCEL_EN.
- Defined: |d| > 4*DEADZONE uses step magnitude 2*SPEED, with the same sign rules and clamping. The threshold comparison is strict.
- Undefined: step magnitude is always SPEED, and no extra comparator logic is present.

Test Plan:
- Calibration: clr pulse → paddle_y=208, cal_done=0. Then 8 jstk_valid with y_raw=500 → cal_done=1 on the edge of the 8th valid, and centre=500.
- Movement up: after calibration at 500, 4 valids with y_raw=900 (avg=900, d=400), then 3 frame_ticks with enable=1 → paddle_y=196. With PADDLE_ACCEL_EN defined → paddle_y=184.
- Dead zone: y_raw=564 (d=64), then 10 frame_ticks → paddle_y unchanged. Then y_raw=565 (d=65), 1 tick → paddle_y decreases by 4.
- Clamp, bottom: y_raw=100 held for 200 frame_ticks → paddle_y saturates at 416 and stays there.
- Clamp, top: y_raw=1000 held → paddle_y reaches 0 with no wrap. Setting paddle_y=2 and applying one tick yields 0.
- Gating and reset:
  - enable=0 with d=400 over 5 ticks → paddle_y holds; buttons still track jstk_data[2:1].
  - clr asserted in RUN → next cycle paddle_y=208, cal_done=0; ticks ignored until 8 new valids.
